// File: rtl/alu_cc_writeback_if.sv
// Handshake and data bundle between the ALU stage, the condition-code/writeback
// buffer and its consumers.
interface alu_cc_writeback_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] alu_out;
  logic             set_cc;
  logic [3:0]       dst_id;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [3:0]       out_dst;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic [3:0]       cond_fn;
  logic             cond_true;

  modport master (
    output in_valid, alu_mode, a, b, alu_out, set_cc, dst_id, out_ready, cond_fn,
    input  in_ready, out_valid, out_result, out_dst, cc_zf, cc_sf, cc_of, cond_true
  );

  modport slave (
    input  in_valid, alu_mode, a, b, alu_out, set_cc, dst_id, out_ready, cond_fn,
    output in_ready, out_valid, out_result, out_dst, cc_zf, cc_sf, cc_of, cond_true
  );
endinterface

// File: rtl/alu_cc_writeback.sv
// ALU condition-code register, branch/cmov condition evaluation and in-order
// result FIFO toward writeback. Define ALU_CC_FWD_EN for same-cycle flag forwarding.
module alu_cc_writeback #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                reset,
  alu_cc_writeback_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic cc_t calc_flags(input logic [1:0] mode, input logic [WIDTH-1:0] op_a,
                                     input logic [WIDTH-1:0] op_b, input logic [WIDTH-1:0] res);
    cc_t f;
    f.zf = (res == {WIDTH{1'b0}});
    f.sf = res[WIDTH-1];
    case (mode)
      2'b00:   f.of = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      2'b01:   f.of = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
      default: f.of = 1'b0;
    endcase
    return f;
  endfunction

  // Signed-compare style conditions; l is "less than" after a subtract.
  function automatic logic cond_eval(input logic [3:0] fn, input cc_t f);
    logic l;
    logic r;
    l = f.sf ^ f.of;
    case (fn)
      4'd0:    r = 1'b1;
      4'd1:    r = l | f.zf;
      4'd2:    r = l;
      4'd3:    r = f.zf;
      4'd4:    r = ~f.zf;
      4'd5:    r = ~l;
      4'd6:    r = ~l & ~f.zf;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] data_mem_r [DEPTH];
  logic [3:0]       dst_mem_r  [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  cc_t              cc_r;
  cc_t              new_cc_s;
  cc_t              eval_cc_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode; readiness depends only on the registered count.
  always_comb begin
    push_s   = bus.in_valid && (count_r < DEPTH_C);
    pop_s    = bus.out_ready && (count_r != {CNT_W{1'b0}});
    new_cc_s = calc_flags(bus.alu_mode, bus.a, bus.b, bus.alu_out);
  end

`ifdef ALU_CC_FWD_EN
  // Flags of the op being accepted bypass the register for same-cycle branches.
  always_comb begin
    if (push_s && bus.set_cc) begin
      eval_cc_s = new_cc_s;
    end else begin
      eval_cc_s = cc_r;
    end
  end
`else
  // Conditions see only the registered flags.
  always_comb begin
    eval_cc_s = cc_r;
  end
`endif

  // FIFO head presentation; an empty FIFO shows zeros.
  always_comb begin
    bus.in_ready  = (count_r < DEPTH_C);
    bus.out_valid = (count_r != {CNT_W{1'b0}});
    bus.cc_zf     = cc_r.zf;
    bus.cc_sf     = cc_r.sf;
    bus.cc_of     = cc_r.of;
    bus.cond_true = cond_eval(bus.cond_fn, eval_cc_s);
    if (bus.out_valid) begin
      bus.out_result = data_mem_r[head_r];
      bus.out_dst    = dst_mem_r[head_r];
    end else begin
      bus.out_result = {WIDTH{1'b0}};
      bus.out_dst    = 4'd0;
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[tail_r] <= bus.alu_out;
      dst_mem_r[tail_r]  <= bus.dst_id;
    end
  end

  // Pointers, occupancy and condition-code register; reset wins over traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      cc_r    <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && bus.set_cc) begin
        cc_r <= new_cc_s;
      end
    end
  end
endmodule

// File: tb/tb_alu_cc_writeback.sv
// Directed plus randomized bench for alu_cc_writeback against a queue-based
// reference model; honours ALU_CC_FWD_EN when defined.
module tb_alu_cc_writeback;
  localparam int W     = 64;
  localparam int DEPTH = 2;

  typedef struct {
    logic [W-1:0] result;
    logic [3:0]   dst;
  } entry_t;

  logic clk;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  entry_t q[$];
  logic   m_zf, m_sf, m_of;

  alu_cc_writeback_if #(.WIDTH(W)) bus ();

  alu_cc_writeback #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_alu(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    case (m)
      2'd0:    return x + y;
      2'd1:    return x - y;
      2'd2:    return x & y;
      default: return x ^ y;
    endcase
  endfunction

  // Flags from the true (65-bit) signed result: overflow when it does not fit in W bits.
  function automatic logic [2:0] model_flags(input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W:0] wide;
    logic [W-1:0]      res;
    logic              ovf;
    res = model_alu(m, x, y);
    case (m)
      2'd0:    begin wide = $signed({x[W-1], x}) + $signed({y[W-1], y}); ovf = (wide != $signed({res[W-1], res})); end
      2'd1:    begin wide = $signed({x[W-1], x}) - $signed({y[W-1], y}); ovf = (wide != $signed({res[W-1], res})); end
      default: ovf = 1'b0;
    endcase
    return {(res == '0), res[W-1], ovf};
  endfunction

  function automatic logic model_cond(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt | zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return ~zf;
      4'd5:    return ~lt;
      4'd6:    return ~lt & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] m, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit sc, input logic [3:0] d);
    bus.in_valid = v;
    bus.alu_mode = m;
    bus.a        = x;
    bus.b        = y;
    bus.alu_out  = model_alu(m, x, y);
    bus.set_cc   = sc;
    bus.dst_id   = d;
  endtask

  // Advance one clock edge and update the model with what that edge should do.
  task automatic tick();
    bit          acc, pp;
    logic [2:0]  f;
    entry_t      e;
    acc = bus.in_valid && (q.size() < DEPTH);
    pp  = bus.out_ready && (q.size() != 0);
    f   = model_flags(bus.alu_mode, bus.a, bus.b);
    e.result = bus.alu_out;
    e.dst    = bus.dst_id;
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
      {m_zf, m_sf, m_of} = 3'b100;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (acc && bus.set_cc) {m_zf, m_sf, m_of} = f;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [2:0] ef;
    ef = {m_zf, m_sf, m_of};
`ifdef ALU_CC_FWD_EN
    if (bus.in_valid && (q.size() < DEPTH) && bus.set_cc) ef = model_flags(bus.alu_mode, bus.a, bus.b);
`endif
    #1;
    chk({tag, ".out_valid"}, bus.out_valid, q.size() != 0);
    chk({tag, ".in_ready"},  bus.in_ready,  q.size() < DEPTH);
    chk({tag, ".out_result"}, bus.out_result, (q.size() != 0) ? q[0].result : '0);
    chk({tag, ".out_dst"},   bus.out_dst,   (q.size() != 0) ? q[0].dst : 4'd0);
    chk({tag, ".cc"}, {bus.cc_zf, bus.cc_sf, bus.cc_of}, {m_zf, m_sf, m_of});
    chk({tag, ".cond_true"}, bus.cond_true, model_cond(bus.cond_fn, ef[2], ef[1], ef[0]));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return 64'h7FFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'(int'($urandom_range(0, 7)) - 3);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    bit done;
    logic [W-1:0] x, y;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    reset = 1'b1;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    bus.out_ready = 1'b0;
    bus.cond_fn   = 4'd3;
    tick();
    tick();
    reset = 1'b0;
    check_outputs("reset_idle");

    // Signed overflow on add.
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd7);
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    bus.cond_fn = 4'd2;
    check_outputs("add_ovf_fn2");
    bus.cond_fn = 4'd5;
    check_outputs("add_ovf_fn5");

    // Equal subtract, then xor without flag update.
    drive(1'b1, 2'd1, 64'd5, 64'd5, 1'b1, 4'd8);
    tick();
    drive(1'b1, 2'd3, 64'hF0, 64'h0F, 1'b0, 4'd9);
    bus.cond_fn = 4'd3;
    check_outputs("sub_eq");
    tick();
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    check_outputs("xor_nocc");
    tick();
    check_outputs("drain");

    // Backpressure: third result waits for space.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'd0, 64'(i), 64'd100, 1'b0, 4'(i));
      check_outputs($sformatf("fill%0d", i));
      if (i < 3) tick();
    end
    tick();
    check_outputs("full_hold");
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      if (q.size() < DEPTH) done = 1'b1;
      tick();
      if (done) drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
      check_outputs($sformatf("release%0d", k));
    end
    chk("third_accepted", done, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_outputs($sformatf("drain%0d", k));
    end

    // Streaming at count 1: accept and pop every cycle.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd2, 64'hFF, 64'h3C, 1'b1, 4'd0);
    tick();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, 2'd0, 64'(k * 3), 64'(k), 1'b1, 4'(k));
      bus.cond_fn = 4'(k % 8);
      check_outputs($sformatf("stream%0d", k));
      tick();
    end
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    check_outputs("stream_end");
    chk("stream_count", q.size(), 1);
    tick();

    // Reset with two entries buffered and CC = 0/1/1.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'd1);
    tick();
    drive(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 4'd2);
    tick();
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    check_outputs("pre_reset");
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs("post_reset");

    // Same-cycle resolution (forwarded only when the option is built in).
    drive(1'b1, 2'd1, 64'd1, 64'd2, 1'b1, 4'd4);
    bus.cond_fn = 4'd2;
    check_outputs("fwd_sub");
    tick();
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    check_outputs("fwd_after");

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      x = pick_operand();
      y = ($urandom_range(0, 7) == 0) ? x : pick_operand();
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), x, y,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.cond_fn   = 4'($urandom_range(0, 15));
      reset         = ($urandom_range(0, 49) == 0);
      check_outputs($sformatf("rand%0d", k));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    check_outputs("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_cc_writeback.md
Name: alu_cc_writeback

Overview:
- Sits directly downstream of the combinational 64-bit ALU (add/sub/and/xor).
- Each cycle it accepts one ALU result together with its operands and mode.
- From the operands and mode it computes and holds the ZF/SF/OF condition-code register.
- Evaluates branch/cmov conditions from that register, and buffers results in a small in-order FIFO toward writeback under a valid/ready handshake.

Parameters:
- WIDTH, 64, operand/result width in bits.
- DEPTH, 2, result FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ALU result presented
- in_ready  output  1  block can accept
- alu_mode  input  2  00 add, 01 sub (a-b), 10 and, 11 xor
- a  input  WIDTH  ALU operand a
- b  input  WIDTH  ALU operand b
- alu_out  input  WIDTH  ALU result for a/b/alu_mode
- set_cc  input  1  this op updates condition codes
- dst_id  input  4  destination register id
- out_valid  output  1  FIFO head valid
- out_ready  input  1  writeback consumes head
- out_result  output  WIDTH  head result
- out_dst  output  4  head destination id
- cc_zf, cc_sf, cc_of  output  1 each  condition-code register
- cond_fn  input  4  condition selector
- cond_true  output  1  condition evaluation

Behaviour:
- Clock and reset: single clock domain; all state updates on rising clk; reset is synchronous and active-high.
- Reset values: FIFO empty, out_valid=0, out_result=0, out_dst=0, cc_zf=1, cc_sf=0, cc_of=0. Reset wins over any same-cycle accept or pop.
- Accept: occurs when in_valid & in_ready. in_ready = (count < DEPTH), registered-count based with no combinational path from out_ready. A full FIFO refuses input even if out_ready=1 that cycle.
- Pop: occurs when out_valid & out_ready. out_valid = (count != 0). out_result/out_dst show the head entry directly (FIFO read, no extra register stage).
- Latency: an accepted result appears at out_* on the cycle after acceptance (1 cycle) if the FIFO was empty.
- Simultaneous accept+pop (count between 1 and DEPTH-1): count unchanged, order preserved. Pointers wrap modulo DEPTH.
- Condition-code update: on accept with set_cc=1, the CC register loads new flags in the same edge. Accept with set_cc=0 leaves CC unchanged. CC is never affected by pops or stalls.
  - ZF = (alu_out == 0).
  - SF = alu_out[WIDTH-1].
  - OF for add: a[W-1]==b[W-1] and alu_out[W-1]!=a[W-1].
  - OF for sub: a[W-1]!=b[W-1] and alu_out[W-1]!=a[W-1].
  - OF for and/xor: 0.
- Condition evaluation: cond_true is combinational from the registered CC. Let L = SF^OF.
  - cond_fn 0: 1
  - cond_fn 1: L|ZF
  - cond_fn 2: L
  - cond_fn 3: ZF
  - cond_fn 4: ~ZF
  - cond_fn 5: ~L
  - cond_fn 6: ~L&~ZF
  - cond_fn 7-15: 0
- Reset mid-stream: all buffered entries are discarded and CC returns to 1/0/0.
- Arithmetic: all flag logic is on WIDTH bits; carry-out is not tracked.

Optional Feature:
- Macro: ALU_CC_FWD_EN.
- Defined: cond_true uses the flags of the op being accepted this cycle when in_valid & in_ready & set_cc, and the registered CC otherwise. This gives a same-cycle branch resolution path.
- Undefined: cond_true uses only the registered CC, so a new op's flags are visible one cycle after its acceptance.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, cc_zf/sf/of = 1/0/0, cond_fn=3 gives cond_true=1.
- add a=0x7FFF_FFFF_FFFF_FFFF, b=1, alu_out=0x8000_0000_0000_0000, set_cc=1 -> next cycle ZF=0, SF=1, OF=1; cond_fn=2 gives 0, cond_fn=5 gives 1.
- sub a=5, b=5, alu_out=0, set_cc=1 -> ZF=1, SF=0, OF=0; then xor with set_cc=0 -> CC unchanged.
- Hold out_ready=0, send 3 results (dst 1, 2, 3) -> first two accepted, in_ready=0 on the third; release out_ready -> dst 1, 2, 3 pop in order, third accepted only after space frees.
- Accept and pop same cycle with count=1 for 10 cycles -> count stays 1, results ordered, no drop/duplicate.
- Assert reset with 2 entries buffered and CC=0/1/1 -> next cycle out_valid=0, CC=1/0/0; with ALU_CC_FWD_EN, accepting sub a=1, b=2 with set_cc=1 drives cond_fn=2 gives cond_true=1 in the accept cycle.
